layer_zorder_controller: RTL and testbench

Owns the per-layer z-index bus consumed by the display layer mux (smaller z-index drawn on top; on equal z-index the lower layer number wins). It accepts reorder commands from game logic over a valid/ready handshake. Each accepted command is held until the next start-of-frame pulse, then applied in a fixed multi-cycle sweep. The new ordering is committed atomically, so a frame is never drawn with a half-updated z-order.

---
 rtl/layer_zorder_controller_if.sv | 21 ++
 rtl/layer_zorder_controller.sv | 115 +++++++++++
 tb/tb_layer_zorder_controller.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_zorder_controller_if.sv
// rtl/layer_zorder_controller_if.sv - reorder command handshake between game logic and the z-order controller
interface layer_zorder_controller_if #(
    parameter int LOG_NUM_UNITS = 2
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [1:0]               cmd_op;
    logic [LOG_NUM_UNITS-1:0] cmd_layer_a;
    logic [LOG_NUM_UNITS-1:0] cmd_layer_b;
    logic [3:0]               cmd_z;

    modport master (
        output cmd_valid, cmd_op, cmd_layer_a, cmd_layer_b, cmd_z,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_layer_a, cmd_layer_b, cmd_z,
        output cmd_ready
    );
endinterface

// File: rtl/layer_zorder_controller.sv
// rtl/layer_zorder_controller.sv - per-layer z-index owner; applies one reorder command per frame, committed atomically
module layer_zorder_controller #(
    parameter int NUM_UNITS     = 4,
    parameter int LOG_NUM_UNITS = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          startOfFrame,
    layer_zorder_controller_if.slave      cmd,
    output logic [NUM_UNITS-1:0][3:0]     layerZIndexes,
    output logic                          busy,
    output logic                          cmd_done,
    output logic                          cmd_err
);
    localparam logic [1:0] OP_FRONT = 2'b00;
    localparam logic [1:0] OP_BACK  = 2'b01;
    localparam logic [1:0] OP_SWAP  = 2'b10;
    localparam logic [1:0] OP_SET   = 2'b11;

    localparam logic [LOG_NUM_UNITS:0]   NU    = (LOG_NUM_UNITS+1)'(NUM_UNITS);
    localparam logic [LOG_NUM_UNITS-1:0] JLAST = LOG_NUM_UNITS'(NUM_UNITS - 1);
    localparam logic [3:0]               ZMAX  = 4'(NUM_UNITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_APPLY, S_COMMIT} state_t;

    state_t                   state, state_nx;
    logic [1:0]               op_q;
    logic [LOG_NUM_UNITS-1:0] a_q, b_q, j_q;
    logic [3:0]               cz_q, za_q, zb_q, zj, z_new;
    logic                     rej_q, a_ok, b_ok, accept;
    logic [NUM_UNITS-1:0][3:0] shadow;

    assign accept = cmd.cmd_valid && cmd.cmd_ready;
    assign a_ok   = {1'b0, cmd.cmd_layer_a} < NU;
    assign b_ok   = {1'b0, cmd.cmd_layer_b} < NU;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (cmd.cmd_valid) state_nx = S_WAIT;
            S_WAIT:   if (startOfFrame)  state_nx = S_APPLY;
            S_APPLY:  if (j_q == JLAST)  state_nx = S_COMMIT;
            S_COMMIT: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        cmd.cmd_ready = (state == S_IDLE);
        busy          = (state != S_IDLE);
    end

    // Next value for layer j, computed from the still-active z-index so the mux never sees partial updates.
    always_comb begin
        zj    = layerZIndexes[j_q];
        z_new = zj;
        if (!rej_q) begin
            case (op_q)
                OP_FRONT: if (j_q == a_q) z_new = 4'd0;
                          else if (zj < za_q) z_new = zj + 4'd1;
                OP_BACK:  if (j_q == a_q) z_new = ZMAX;
                          else if (zj > za_q) z_new = zj - 4'd1;
                OP_SWAP:  if (j_q == a_q) z_new = zb_q;
                          else if (j_q == b_q) z_new = za_q;
                OP_SET:   if (j_q == a_q) z_new = cz_q;
                default:  z_new = zj;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                layerZIndexes[i] <= 4'(i);
                shadow[i]        <= 4'(i);
            end
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            j_q      <= '0;
            cz_q     <= '0;
            za_q     <= '0;
            zb_q     <= '0;
            rej_q    <= 1'b0;
            cmd_done <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            cmd_done <= 1'b0;
            cmd_err  <= 1'b0;
            if (accept) begin
                op_q  <= cmd.cmd_op;
                a_q   <= cmd.cmd_layer_a;
                b_q   <= cmd.cmd_layer_b;
                cz_q  <= cmd.cmd_z;
                za_q  <= a_ok ? layerZIndexes[cmd.cmd_layer_a] : 4'd0;
                zb_q  <= b_ok ? layerZIndexes[cmd.cmd_layer_b] : 4'd0;
                rej_q <= !a_ok || (cmd.cmd_op == OP_SWAP && !b_ok);
            end
            if (state == S_APPLY) begin
                shadow[j_q] <= z_new;
                j_q         <= (j_q == JLAST) ? '0 : j_q + 1'b1;
            end
            if (state == S_COMMIT) begin
                layerZIndexes <= shadow;
                cmd_done      <= 1'b1;
                cmd_err       <= rej_q;
            end
        end
    end
endmodule

// File: tb/tb_layer_zorder_controller.sv
// tb/tb_layer_zorder_controller.sv - scoreboard bench for layer_zorder_controller (4-layer and 3-layer instances)
module tb_layer_zorder_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sof = 1'b0;
    always #5 clk = ~clk;

    layer_zorder_controller_if #(.LOG_NUM_UNITS(2)) cif0 ();
    layer_zorder_controller_if #(.LOG_NUM_UNITS(2)) cif1 ();

    logic [3:0][3:0] z0;
    logic [2:0][3:0] z1;
    logic busy0, done0, err0, busy1, done1, err1;

    layer_zorder_controller #(.NUM_UNITS(4), .LOG_NUM_UNITS(2)) dut0 (
        .clk(clk), .reset(reset), .startOfFrame(sof), .cmd(cif0.slave),
        .layerZIndexes(z0), .busy(busy0), .cmd_done(done0), .cmd_err(err0)
    );
    layer_zorder_controller #(.NUM_UNITS(3), .LOG_NUM_UNITS(2)) dut1 (
        .clk(clk), .reset(reset), .startOfFrame(sof), .cmd(cif1.slave),
        .layerZIndexes(z1), .busy(busy1), .cmd_done(done1), .cmd_err(err1)
    );

    int checks = 0;
    int errors = 0;
    logic [16:0] q0[$];
    logic [16:0] q1[$];
    logic [15:0] m0, m1;
    logic [15:0] prev0, prev1;
    logic prev_rst = 1'b1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: z-order as a list of per-layer values rewritten by the command rules.
    function automatic logic [16:0] ref_apply(input logic [15:0] zin, input int n, input int op,
                                              input int a, input int b, input int cz);
        logic [15:0] zout;
        int za, zb, zi;
        zout = zin;
        if (a >= n || (op == 2 && b >= n)) return {1'b1, zin};
        za = int'(zin[a*4 +: 4]);
        zb = int'(zin[b*4 +: 4]);
        for (int i = 0; i < n; i++) begin
            zi = int'(zin[i*4 +: 4]);
            case (op)
                0: zi = (i == a) ? 0 : (zi < za) ? (zi + 1) % 16 : zi;
                1: zi = (i == a) ? n - 1 : (zi > za) ? (zi + 15) % 16 : zi;
                2: zi = (i == a) ? zb : (i == b) ? za : zi;
                default: zi = (i == a) ? cz : zi;
            endcase
            zout[i*4 +: 4] = 4'(zi);
        end
        return {1'b0, zout};
    endfunction

    always @(negedge clk) begin
        if (!reset && done0) begin
            if (q0.size() == 0) check("dut0_spurious_done", 1, 0);
            else begin
                logic [16:0] e;
                e = q0.pop_front();
                check("dut0_z", 32'(z0), 32'(e[15:0]));
                check("dut0_err", 32'(err0), 32'(e[16]));
            end
        end
        if (!reset && done1) begin
            if (q1.size() == 0) check("dut1_spurious_done", 1, 0);
            else begin
                logic [16:0] e;
                e = q1.pop_front();
                check("dut1_z", 32'(z1), 32'(e[11:0]));
                check("dut1_err", 32'(err1), 32'(e[16]));
            end
        end
        if (err0) check("dut0_err_needs_done", 32'(done0), 1);
        if (err1) check("dut1_err_needs_done", 32'(done1), 1);
        if (!prev_rst && !done0 && z0 !== prev0) check("dut0_z_stable", 32'(z0), 32'(prev0));
        if (!prev_rst && !done1 && z1 !== prev1[11:0]) check("dut1_z_stable", 32'(z1), 32'(prev1));
        prev0 = z0;
        prev1 = {4'h0, z1};
        prev_rst = reset;
    end

    task automatic set_cmd(input int sel, input logic v, input int op, input int a, input int b, input int cz);
        if (sel == 0) begin
            cif0.cmd_valid = v; cif0.cmd_op = 2'(op); cif0.cmd_layer_a = 2'(a);
            cif0.cmd_layer_b = 2'(b); cif0.cmd_z = 4'(cz);
        end else begin
            cif1.cmd_valid = v; cif1.cmd_op = 2'(op); cif1.cmd_layer_a = 2'(a);
            cif1.cmd_layer_b = 2'(b); cif1.cmd_z = 4'(cz);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m0 = 16'h3210;
        m1 = 16'h0210;
        q0.delete();
        q1.delete();
    endtask

    // Push the expected commit, then drive the command for one accept edge (starts/ends at a negedge).
    task automatic issue(input int sel, input int op, input int a, input int b, input int cz, input logic with_sof);
        logic [16:0] r;
        if (sel == 0) begin
            r = ref_apply(m0, 4, op, a, b, cz); m0 = r[15:0]; q0.push_back(r);
            check("ready_before_accept", 32'(cif0.cmd_ready), 1);
        end else begin
            r = ref_apply(m1, 3, op, a, b, cz); m1 = r[15:0]; q1.push_back(r);
            check("ready_before_accept", 32'(cif1.cmd_ready), 1);
        end
        set_cmd(sel, 1'b1, op, a, b, cz);
        sof = with_sof;
        @(negedge clk);
        sof = 1'b0;
        set_cmd(sel, 1'b0, 0, 0, 0, 0);
        check("busy_after_accept", (sel == 0) ? 32'(busy0) : 32'(busy1), 1);
        check("ready_after_accept", (sel == 0) ? 32'(cif0.cmd_ready) : 32'(cif1.cmd_ready), 0);
    endtask

    task automatic pulse();
        sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
    endtask

    // Called in cycle t+1 after a pulse in cycle t; commit must first be visible in cycle t+n+2.
    task automatic wait_done(input int sel, input int exp_k);
        int k;
        bit seen;
        seen = 0;
        k = 1;
        for (int c = 1; c <= 40; c++) begin
            if ((sel == 0) ? done0 : done1) begin
                seen = 1;
                k = c;
                break;
            end
            @(negedge clk);
        end
        check("commit_latency", seen ? k : 0, exp_k);
        if (seen) begin
            check("ready_at_done", (sel == 0) ? 32'(cif0.cmd_ready) : 32'(cif1.cmd_ready), 1);
            check("busy_at_done", (sel == 0) ? 32'(busy0) : 32'(busy1), 0);
            @(negedge clk);
        end
    endtask

    task automatic run(input int sel, input int op, input int a, input int b, input int cz, input int gap);
        issue(sel, op, a, b, cz, 1'b0);
        repeat (gap) @(negedge clk);
        pulse();
        wait_done(sel, (sel == 0) ? 6 : 5);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        set_cmd(0, 1'b0, 0, 0, 0, 0);
        set_cmd(1, 1'b0, 0, 0, 0, 0);
        @(negedge clk);
        do_reset();
        check("reset_z0", 32'(z0), 32'h3210);
        check("reset_z1", 32'(z1), 32'h210);
        check("reset_ready", 32'(cif0.cmd_ready), 1);
        check("reset_busy", 32'(busy0), 0);
        check("reset_done", 32'(done0), 0);

        run(0, 0, 2, 0, 0, 2);
        check("front_a2", 32'(z0), 32'h3021);

        do_reset();
        run(0, 1, 0, 0, 0, 1);
        check("back_a0", 32'(z0), 32'h2103);
        issue(0, 2, 1, 3, 0, 1'b0);
        cnt = 0;
        repeat (1000) begin
            @(negedge clk);
            if (busy0 !== 1'b1 || done0 !== 1'b0) cnt++;
        end
        check("no_frame_hold", cnt, 0);
        pulse();
        wait_done(0, 6);
        check("swap_13", 32'(z0), 32'h0123);

        do_reset();
        run(0, 3, 3, 0, 0, 0);
        check("set_a3_z0", 32'(z0), 32'h0210);
        run(0, 2, 1, 1, 0, 3);
        check("swap_self", 32'(z0), 32'h0210);

        do_reset();
        issue(0, 0, 3, 0, 0, 1'b1);
        cnt = 0;
        repeat (10) begin
            if (done0 !== 1'b0) cnt++;
            @(negedge clk);
        end
        check("same_cycle_sof_ignored", cnt, 0);
        pulse();
        wait_done(0, 6);

        do_reset();
        issue(0, 0, 1, 0, 0, 1'b0);
        pulse();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_apply_reset_z", 32'(z0), 32'h3210);
        check("mid_apply_reset_busy", 32'(busy0), 0);
        check("mid_apply_reset_ready", 32'(cif0.cmd_ready), 1);
        reset = 1'b0;
        m0 = 16'h3210;
        m1 = 16'h0210;
        q0.delete();
        q1.delete();
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done0 !== 1'b0) cnt++;
        end
        check("mid_apply_no_done", cnt, 0);

        run(1, 0, 3, 0, 0, 1);
        check("n3_reject_z", 32'(z1), 32'h210);
        run(1, 2, 0, 3, 0, 0);
        check("n3_swap_reject_z", 32'(z1), 32'h210);
        run(1, 1, 0, 0, 0, 2);
        check("n3_back_a0", 32'(z1), 32'h102);

        repeat (25) run(0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 15), $urandom_range(0, 3));
        repeat (12) run(1, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 15), $urandom_range(0, 3));

        repeat (3) @(negedge clk);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
